// File: rtl/pipe_ctrl_seq.sv
// Pipelined MIPS control: ID-stage decode into an ID/EX register, hazard stalls,
// branch/jump redirect and tracking of a multicycle mult/div unit.
module pipe_ctrl_seq #(
  parameter int MUL_LAT = 4,
  parameter int DIV_EN  = 1,
  parameter int DIV_LAT = 16,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              eq_ne,
  output logic              stall,
  output logic              flush_if,
  output logic [1:0]        pc_source,
  output logic              ex_memwrite,
  output logic              ex_regwrite,
  output logic              ex_memtoreg,
  output logic              ex_regdst,
  output logic              ex_mfsrc,
  output logic [1:0]        ex_alusrc,
  output logic [3:0]        ex_alu_op,
  output logic [REG_AW-1:0] ex_dest,
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic              md_busy
);
  localparam int CW = 6;
  localparam logic [CW-1:0] MUL_C = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_C = CW'(DIV_LAT);

  typedef struct packed {
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       regdst;
    logic       mfsrc;
    logic [1:0] alusrc;
    logic [3:0] alu_op;
  } ctrl_t;

  ctrl_t             dc, ex_q;
  logic              r_alu, reads_rt, is_md, is_mf, is_br, is_bne, is_j;
  logic [1:0]        dc_mdop;
  logic [CW-1:0]     cnt;
  logic              lu_haz, br_haz, md_haz, stall_i, taken, redirect, issue;

  always_comb begin
    dc        = '0;
    dc.alu_op = 4'b0010;
    r_alu     = 1'b0;
    reads_rt  = 1'b0;
    is_md     = 1'b0;
    is_mf     = 1'b0;
    is_br     = 1'b0;
    is_bne    = 1'b0;
    is_j      = 1'b0;
    dc_mdop   = 2'b00;
    case (op)
      6'b000000: begin
        reads_rt = 1'b1;
        case (func)
          6'b100000, 6'b100001: begin r_alu = 1'b1; dc.alu_op = 4'b0010; end
          6'b100010, 6'b100011: begin r_alu = 1'b1; dc.alu_op = 4'b1010; end
          6'b100100:            begin r_alu = 1'b1; dc.alu_op = 4'b0000; end
          6'b100101:            begin r_alu = 1'b1; dc.alu_op = 4'b0001; end
          6'b100110:            begin r_alu = 1'b1; dc.alu_op = 4'b0101; end
          // xnor lives in the nor function slot on this core
          6'b100111:            begin r_alu = 1'b1; dc.alu_op = 4'b1101; end
          6'b101010:            begin r_alu = 1'b1; dc.alu_op = 4'b1100; end
          6'b101011:            begin r_alu = 1'b1; dc.alu_op = 4'b1011; end
          6'b010000, 6'b010010: begin
            r_alu     = 1'b1;
            is_mf     = 1'b1;
            dc.alusrc = 2'b11;
            dc.alu_op = 4'b0111;
            dc.mfsrc  = func[1];
          end
          6'b011000: begin is_md = 1'b1; dc_mdop = 2'b00; end
          6'b011001: begin is_md = 1'b1; dc_mdop = 2'b01; end
          6'b011010: begin is_md = (DIV_EN != 0); dc_mdop = 2'b10; end
          6'b011011: begin is_md = (DIV_EN != 0); dc_mdop = 2'b11; end
          default: ;
        endcase
        dc.regwrite = r_alu;
        dc.regdst   = r_alu;
      end
      6'b001000, 6'b001001: begin dc.regwrite = 1'b1; dc.alusrc = 2'b01; dc.alu_op = 4'b0010; end
      6'b001010:            begin dc.regwrite = 1'b1; dc.alusrc = 2'b01; dc.alu_op = 4'b1100; end
      6'b001011:            begin dc.regwrite = 1'b1; dc.alusrc = 2'b01; dc.alu_op = 4'b1011; end
      6'b001100:            begin dc.regwrite = 1'b1; dc.alusrc = 2'b10; dc.alu_op = 4'b0000; end
      6'b001101:            begin dc.regwrite = 1'b1; dc.alusrc = 2'b10; dc.alu_op = 4'b0001; end
      6'b001110:            begin dc.regwrite = 1'b1; dc.alusrc = 2'b10; dc.alu_op = 4'b0101; end
      6'b001111:            begin dc.regwrite = 1'b1; dc.alusrc = 2'b01; dc.alu_op = 4'b0110; end
      6'b100011: begin
        dc.regwrite = 1'b1;
        dc.memtoreg = 1'b1;
        dc.alusrc   = 2'b01;
      end
      6'b101011: begin
        dc.memwrite = 1'b1;
        dc.alusrc   = 2'b01;
        reads_rt    = 1'b1;
      end
      6'b000100: begin is_br = 1'b1; reads_rt = 1'b1; end
      6'b000101: begin is_br = 1'b1; is_bne = 1'b1; reads_rt = 1'b1; end
      6'b000010: is_j = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    lu_haz   = ex_q.memtoreg && (ex_dest != '0) &&
               ((ex_dest == id_rs) || (reads_rt && (ex_dest == id_rt)));
    br_haz   = is_br && ex_q.regwrite && (ex_dest != '0) &&
               ((ex_dest == id_rs) || (ex_dest == id_rt));
    md_haz   = (is_mf || is_md) && md_busy;
    stall_i  = id_valid && (lu_haz || br_haz || md_haz);
    taken    = is_br && (is_bne ? !eq_ne : eq_ne);
    redirect = id_valid && !stall_i && (taken || is_j);
    issue    = id_valid && !stall_i && is_md;
    stall    = rst_n && stall_i;
    flush_if = rst_n && redirect;
    pc_source = 2'b00;
    if (rst_n && redirect) pc_source = is_j ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= '0;
      ex_dest  <= '0;
      md_start <= 1'b0;
      md_op    <= 2'b00;
      md_busy  <= 1'b0;
      cnt      <= '0;
    end else begin
      if (id_valid && !stall_i) begin
        ex_q    <= dc;
        ex_dest <= dc.regdst ? id_rd : id_rt;
      end else begin
        ex_q    <= '0;
        ex_dest <= '0;
      end
      md_start <= issue;
      if (issue) begin
        md_op   <= dc_mdop;
        md_busy <= 1'b1;
        cnt     <= dc_mdop[1] ? DIV_C : MUL_C;
      end else if (md_busy) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) md_busy <= 1'b0;
      end
    end
  end

  assign ex_memwrite = ex_q.memwrite;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_regdst   = ex_q.regdst;
  assign ex_mfsrc    = ex_q.mfsrc;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_alu_op   = ex_q.alu_op;
endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Scoreboard bench for pipe_ctrl_seq: decode sweep, hazards, mult/div tracking,
// branch redirect and reset behaviour; a DIV_EN=0 copy shares the inputs.
module tb_pipe_ctrl_seq;
  logic       clk, rst_n, id_valid, eq_ne;
  logic [5:0] op, func;
  logic [4:0] id_rs, id_rt, id_rd;

  logic       stall, flush_if, md_start, md_busy;
  logic [1:0] pc_source, md_op, ex_alusrc;
  logic       ex_memwrite, ex_regwrite, ex_memtoreg, ex_regdst, ex_mfsrc;
  logic [3:0] ex_alu_op;
  logic [4:0] ex_dest;

  logic       n_stall, n_flush_if, n_md_start, n_md_busy;
  logic [1:0] n_pc_source, n_md_op, n_alusrc;
  logic       n_memwrite, n_regwrite, n_memtoreg, n_regdst, n_mfsrc;
  logic [3:0] n_alu_op;
  logic [4:0] n_dest;

  pipe_ctrl_seq #(.MUL_LAT(4), .DIV_EN(1), .DIV_LAT(16), .REG_AW(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .op(op), .func(func),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .eq_ne(eq_ne),
    .stall(stall), .flush_if(flush_if), .pc_source(pc_source),
    .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_regdst(ex_regdst), .ex_mfsrc(ex_mfsrc), .ex_alusrc(ex_alusrc),
    .ex_alu_op(ex_alu_op), .ex_dest(ex_dest),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy));

  pipe_ctrl_seq #(.MUL_LAT(4), .DIV_EN(0), .DIV_LAT(16), .REG_AW(5)) u_nodiv (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .op(op), .func(func),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .eq_ne(eq_ne),
    .stall(n_stall), .flush_if(n_flush_if), .pc_source(n_pc_source),
    .ex_memwrite(n_memwrite), .ex_regwrite(n_regwrite), .ex_memtoreg(n_memtoreg),
    .ex_regdst(n_regdst), .ex_mfsrc(n_mfsrc), .ex_alusrc(n_alusrc),
    .ex_alu_op(n_alu_op), .ex_dest(n_dest),
    .md_start(n_md_start), .md_op(n_md_op), .md_busy(n_md_busy));

  logic [15:0] ex_vec;
  assign ex_vec = {ex_memwrite, ex_regwrite, ex_memtoreg, ex_regdst, ex_mfsrc,
                   ex_alusrc, ex_alu_op, ex_dest};

  typedef struct {
    logic [15:0] ex;
    logic        mds;
    logic [1:0]  mdop;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0, n_err = 0;
  int busy_cnt = 0, mds_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (md_busy)  busy_cnt <= busy_cnt + 1;
    if (md_start) mds_cnt  <= mds_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected ID/EX bundle {mw,rw,mtr,rdst,mfs,alusrc,alu_op,dest}
  function automatic logic [15:0] exp_ctrl(input logic [5:0] o, f, input logic [4:0] t, d);
    logic mw, rw, mtr, rdst, mfs;
    logic [1:0] src;
    logic [3:0] alu;
    {mw, rw, mtr, rdst, mfs, src} = '0;
    alu = 4'b0010;
    if (o == 6'b000000) begin
      case (f)
        6'b100000, 6'b100001: begin rw = 1; rdst = 1; alu = 4'b0010; end
        6'b100010, 6'b100011: begin rw = 1; rdst = 1; alu = 4'b1010; end
        6'b100100: begin rw = 1; rdst = 1; alu = 4'b0000; end
        6'b100101: begin rw = 1; rdst = 1; alu = 4'b0001; end
        6'b100110: begin rw = 1; rdst = 1; alu = 4'b0101; end
        6'b100111: begin rw = 1; rdst = 1; alu = 4'b1101; end
        6'b101010: begin rw = 1; rdst = 1; alu = 4'b1100; end
        6'b101011: begin rw = 1; rdst = 1; alu = 4'b1011; end
        6'b010000: begin rw = 1; rdst = 1; alu = 4'b0111; src = 2'b11; mfs = 0; end
        6'b010010: begin rw = 1; rdst = 1; alu = 4'b0111; src = 2'b11; mfs = 1; end
        default: ;
      endcase
    end else begin
      case (o)
        6'b001000, 6'b001001: begin rw = 1; src = 2'b01; alu = 4'b0010; end
        6'b001010: begin rw = 1; src = 2'b01; alu = 4'b1100; end
        6'b001011: begin rw = 1; src = 2'b01; alu = 4'b1011; end
        6'b001100: begin rw = 1; src = 2'b10; alu = 4'b0000; end
        6'b001101: begin rw = 1; src = 2'b10; alu = 4'b0001; end
        6'b001110: begin rw = 1; src = 2'b10; alu = 4'b0101; end
        6'b001111: begin rw = 1; src = 2'b01; alu = 4'b0110; end
        6'b100011: begin rw = 1; mtr = 1; src = 2'b01; end
        6'b101011: begin mw = 1; src = 2'b01; end
        default: ;
      endcase
    end
    return {mw, rw, mtr, rdst, mfs, src, alu, (rdst ? d : t)};
  endfunction

  task automatic send(input logic [5:0] o, f, input logic [4:0] s, t, d, input logic e,
                      input int exp_stall, input logic [1:0] exp_pc,
                      input logic exp_md, input logic [1:0] exp_mdop);
    int n = 0;
    logic done = 1'b0;
    exp_t x;
    op = o; func = f; id_rs = s; id_rt = t; id_rd = d; eq_ne = e; id_valid = 1'b1;
    while (!done && n <= 40) begin
      @(negedge clk);
      if (stall) begin
        chk("stall_redirect", {29'd0, flush_if, pc_source}, 32'd0);
        @(posedge clk); #1;
        chk("bubble_ex", {16'd0, ex_vec}, 32'd0);
        chk("bubble_mds", {31'd0, md_start}, 32'd0);
        n++;
      end else begin
        chk("pc_source", {30'd0, pc_source}, {30'd0, exp_pc});
        chk("flush_if", {31'd0, flush_if}, {31'd0, exp_pc != 2'b00});
        q.push_back('{ex: exp_ctrl(o, f, t, d), mds: exp_md, mdop: exp_mdop});
        @(posedge clk); #1;
        x = q.pop_front();
        chk("ex_bundle", {16'd0, ex_vec}, {16'd0, x.ex});
        chk("md_start", {31'd0, md_start}, {31'd0, x.mds});
        if (x.mds) chk("md_op", {30'd0, md_op}, {30'd0, x.mdop});
        done = 1'b1;
      end
    end
    chk("issued", {31'd0, done}, 32'd1);
    chk("stall_cycles", n, exp_stall);
    id_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      chk("idle_ex", {16'd0, ex_vec}, 32'd0);
    end
  endtask

  typedef struct {
    logic [5:0] o, f;
    logic       e;
    logic [1:0] pc;
  } sw_t;

  sw_t sweep[$] = '{
    '{6'b000000, 6'b100000, 0, 2'b00}, '{6'b000000, 6'b100001, 0, 2'b00},
    '{6'b000000, 6'b100010, 0, 2'b00}, '{6'b000000, 6'b100011, 0, 2'b00},
    '{6'b000000, 6'b100100, 0, 2'b00}, '{6'b000000, 6'b100101, 0, 2'b00},
    '{6'b000000, 6'b100110, 0, 2'b00}, '{6'b000000, 6'b100111, 0, 2'b00},
    '{6'b000000, 6'b101010, 0, 2'b00}, '{6'b000000, 6'b101011, 0, 2'b00},
    '{6'b000000, 6'b010000, 0, 2'b00}, '{6'b000000, 6'b010010, 0, 2'b00},
    '{6'b000000, 6'b111111, 0, 2'b00},
    '{6'b001000, 6'b000000, 0, 2'b00}, '{6'b001001, 6'b000000, 0, 2'b00},
    '{6'b001010, 6'b000000, 0, 2'b00}, '{6'b001011, 6'b000000, 0, 2'b00},
    '{6'b001100, 6'b000000, 0, 2'b00}, '{6'b001101, 6'b000000, 0, 2'b00},
    '{6'b001110, 6'b000000, 0, 2'b00}, '{6'b001111, 6'b000000, 0, 2'b00},
    '{6'b100011, 6'b000000, 0, 2'b00}, '{6'b101011, 6'b000000, 0, 2'b00},
    '{6'b111111, 6'b000000, 0, 2'b00},
    '{6'b000100, 6'b000000, 1, 2'b01}, '{6'b000100, 6'b000000, 0, 2'b00},
    '{6'b000101, 6'b000000, 1, 2'b00}, '{6'b000101, 6'b000000, 0, 2'b01},
    '{6'b000010, 6'b000000, 0, 2'b10}
  };

  localparam logic [5:0] R = 6'b000000;

  initial begin
    int b0, m0;
    rst_n = 1'b1; id_valid = 1'b1; op = 6'b000010; func = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; eq_ne = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_flush", {31'd0, flush_if}, 32'd0);
    chk("rst_pc", {30'd0, pc_source}, 32'd0);
    chk("rst_ex", {16'd0, ex_vec}, 32'd0);
    chk("rst_md", {30'd0, md_start, md_busy}, 32'd0);
    id_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (sweep[i]) begin
      send(sweep[i].o, sweep[i].f, 5'd1, 5'd4, 5'd9, sweep[i].e, 0, sweep[i].pc, 1'b0, 2'b00);
      idle(1);
    end

    // load-use: lw $5 then add $6,$5,$7 / add $6,$7,$5; lw $0 never stalls
    send(6'b100011, 6'd0, 5'd1, 5'd5, 5'd0, 0, 0, 2'b00, 1'b0, 2'b00);
    send(R, 6'b100000, 5'd5, 5'd7, 5'd6, 0, 1, 2'b00, 1'b0, 2'b00);
    send(6'b100011, 6'd0, 5'd1, 5'd5, 5'd0, 0, 0, 2'b00, 1'b0, 2'b00);
    send(R, 6'b100000, 5'd7, 5'd5, 5'd6, 0, 1, 2'b00, 1'b0, 2'b00);
    send(6'b100011, 6'd0, 5'd1, 5'd0, 5'd0, 0, 0, 2'b00, 1'b0, 2'b00);
    send(R, 6'b100000, 5'd0, 5'd7, 5'd6, 0, 0, 2'b00, 1'b0, 2'b00);
    idle(1);

    // branch-operand hazard: addi $9 then beq $9,$2 taken
    send(6'b001000, 6'd0, 5'd1, 5'd9, 5'd0, 0, 0, 2'b00, 1'b0, 2'b00);
    send(6'b000100, 6'd0, 5'd9, 5'd2, 5'd0, 1, 1, 2'b01, 1'b0, 2'b00);
    idle(1);

    // mult then mflo back-to-back
    b0 = busy_cnt; m0 = mds_cnt;
    send(R, 6'b011000, 5'd1, 5'd2, 5'd0, 0, 0, 2'b00, 1'b1, 2'b00);
    send(R, 6'b010010, 5'd0, 5'd0, 5'd8, 0, 4, 2'b00, 1'b0, 2'b00);
    chk("mul_busy_cycles", busy_cnt - b0, 4);
    chk("mul_start_pulses", mds_cnt - m0, 1);
    chk("mul_busy_clear", {31'd0, md_busy}, 32'd0);
    idle(1);

    // divu then mult: mult waits out DIV_LAT
    send(R, 6'b011011, 5'd1, 5'd2, 5'd0, 0, 0, 2'b00, 1'b1, 2'b11);
    send(R, 6'b011000, 5'd3, 5'd4, 5'd0, 0, 16, 2'b00, 1'b1, 2'b00);
    idle(20);

    // DIV_EN=0 copy: divu is a NOP, following mult is not held
    op = R; func = 6'b011011; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd0; id_valid = 1'b1;
    @(negedge clk);
    chk("nodiv_div_stall", {31'd0, n_stall}, 32'd0);
    @(posedge clk); #1;
    chk("nodiv_div_start", {31'd0, n_md_start}, 32'd0);
    chk("nodiv_div_busy", {31'd0, n_md_busy}, 32'd0);
    func = 6'b011000;
    @(negedge clk);
    chk("nodiv_mul_stall", {31'd0, n_stall}, 32'd0);
    chk("div_holds_mul", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    idle(20);

    // reset during the second busy cycle of a mult
    send(R, 6'b011000, 5'd1, 5'd2, 5'd0, 0, 0, 2'b00, 1'b1, 2'b00);
    @(posedge clk); #1;
    chk("pre_rst_busy", {31'd0, md_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, md_busy}, 32'd0);
    chk("mid_rst_ex", {16'd0, ex_vec}, 32'd0);
    chk("mid_rst_start", {31'd0, md_start}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(R, 6'b010000, 5'd0, 5'd0, 5'd12, 0, 0, 2'b00, 1'b0, 2'b00);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/pipe_ctrl_seq.md
Name: pipe_ctrl_seq

Overview:
- Pipelined successor to the combinational MIPS decoder: decodes op/func in ID and registers the control bundle into an ID/EX stage.
- Detects load-use, branch-operand and HI/LO hazards, then stalls and inserts bubbles.
- Tracks a multicycle multiply/divide unit with parametrised latencies; optional div/divu support.
- Sits between the IF/ID register and the EX datapath; drives the IF/ID and PC enables.

Parameters:
- MUL_LAT, 4, cycles from mult/multu issue until HI/LO are valid (1..15).
- DIV_EN, 1, when 1, decode div (func 011010) and divu (func 011011); when 0, treat them as a NOP.
- DIV_LAT, 16, cycles from div/divu issue until HI/LO are valid (1..63).
- REG_AW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- op  in  6  opcode.
- func  in  6  R-type function field.
- id_rs, id_rt, id_rd  in  REG_AW  source and destination fields.
- eq_ne  in  1  ID-stage comparator result, 1 = operands equal.
- stall  out  1  hold the PC and IF/ID; combinational.
- flush_if  out  1  squash the IF/ID contents at the next edge; combinational.
- pc_source  out  2  00 = PC+4, 01 = branch target, 10 = jump target; combinational.
- ex_memwrite, ex_regwrite, ex_memtoreg, ex_regdst, ex_mfsrc  out  1 each  registered EX controls.
- ex_alusrc  out  2  00 = register, 01 = sign-extended immediate, 10 = zero-extended immediate, 11 = HI/LO.
- ex_alu_op  out  4  ALU operation code.
- ex_dest  out  REG_AW  registered destination (rd if regdst, else rt).
- md_start  out  1  one-cycle pulse that launches the mult/div unit.
- md_op  out  2  00 = mult, 01 = multu, 10 = div, 11 = divu; valid with md_start.
- md_busy  out  1  mult/div result pending.

Behaviour:
- Reset: every registered output is 0 and the mult/div counter is 0. While rst_n is low, stall and flush_if are 0 and pc_source is 00.
- Decode, ALU codes:
  - add/addu/addi/addiu/lw/sw → 0010.
  - sub/subu → 1010.
  - and/andi → 0000.
  - or/ori → 0001.
  - xor/xori → 0101.
  - xnor → 1101.
  - slt/slti → 1100.
  - sltu/sltiu → 1011.
  - lui → 0110.
  - mfhi/mflo → 0111, with alusrc 11; mfsrc is 0 for HI and 1 for LO.
- Decode, operand source:
  - andi/ori/xori use alusrc 10.
  - Other I-types use alusrc 01.
  - Register-register R-types (arithmetic, logic, set) use 00.
- Decode, writes:
  - R-types write rd.
  - I-types write rt.
  - lw sets memtoreg.
  - sw sets memwrite only.
  - mult/div/branch/j write nothing.
- Unknown encodings decode as NOP: every write/strobe is 0 and alu_op is 0010.
- Latency: decoded controls appear on ex_* one cycle after the ID cycle in which stall = 0.
- Bubble: the ID/EX register loads a NOP when stall = 1, or when id_valid = 0.
- Load-use hazard: stall when all of the following hold:
  - ex_memtoreg = 1 and ex_dest != 0;
  - ex_dest equals id_rs, or equals id_rt for an instruction that reads rt (R-type, sw, beq, bne).
- Branch-operand hazard: stall when beq/bne is in ID, ex_regwrite = 1, ex_dest != 0, and ex_dest equals id_rs or id_rt.
- Mult/div hazards:
  - Stall mfhi/mflo while md_busy = 1.
  - Stall mult/div while md_busy = 1 (no overlapping issue).
- Issue:
  - When mult/multu/div/divu is in ID with stall = 0, assert md_start for one cycle at the next edge.
  - At the same edge, set md_busy and load the counter with MUL_LAT or DIV_LAT.
  - The counter decrements each cycle; md_busy clears on the edge where the counter reaches 0.
  - An mfhi issued in that next cycle proceeds with no stall.
- Branches and jumps:
  - beq is taken when eq_ne = 1; bne is taken when eq_ne = 0.
  - When taken and stall = 0, pc_source = 01.
  - j gives pc_source = 10.
  - In both cases flush_if = 1.
  - When stall = 1, pc_source = 00 and flush_if = 0.
- Stall priority: a hazard stall overrides a branch/jump redirect. The redirect is re-evaluated on the next non-stalled cycle.
- Simultaneous events: counter expiry and an ID-stage mfhi in the same cycle still stall that cycle; the mfhi proceeds next cycle.
- DIV_EN = 0: div/divu produce no md_start and no stall.
- Reset mid-operation: asserting rst_n low clears md_busy and the counter immediately and drops any pending md_start.

Test Plan:
- Decode sweep: apply every supported op/func with id_valid = 1 and no hazards → ex_* fields one cycle later match the decode table above. Example: xori → alusrc 10, alu_op 0101, ex_dest = rt.
- Load-use: lw $5 followed by add $6,$5,$7 → stall = 1 for exactly one cycle, ex_* all zero that cycle, then add issues. With lw $0 → no stall.
- Multiply tracking: MUL_LAT = 4; mult then mflo back-to-back → md_start pulses once, md_busy is high 4 cycles, mflo stalls 4 cycles, then ex_mfsrc = 1 and ex_alusrc = 11.
- Divide and DIV_EN: DIV_LAT = 16, divu then mult → mult stalls 16 cycles and md_op = 11 on the first pulse. Same sequence with DIV_EN = 0 → no md_start, no stall.
- Branches: beq with eq_ne = 1 → pc_source = 01 and flush_if = 1. bne with eq_ne = 1 → pc_source = 00. beq whose rs equals a regwrite dest in EX → one stall cycle, no flush during the stall.
- Reset: drop rst_n low during the 2nd busy cycle of a mult → md_busy = 0 and ex_* = 0 immediately. After release, mfhi issues with no stall.
